direct_mapped_cache: RTL

DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

---
 rtl/direct_mapped_cache.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-back, write-allocate cache with 16-byte lines.
// One request is looked up per cycle; hits answer one cycle after acceptance,
// misses optionally write back the dirty victim and then refill the line.
module direct_mapped_cache #(
  parameter int LINES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req_valid,
  output logic         cpu_req_ready,
  input  logic [31:0]  cpu_req_addr,
  input  logic [31:0]  cpu_req_data,
  input  logic [3:0]   cpu_req_write,
  output logic         cpu_resp_valid,
  output logic [31:0]  cpu_resp_data,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_rw,
  output logic [27:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_data
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 28 - IDX;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    REFILL_REQ,
    REFILL_WAIT
  } state_t;

  state_t state;

  // Latched request; address kept as word address (byte offset bits dropped)
  logic [29:0] lat_addr;
  logic [31:0] lat_data;
  logic [3:0]  lat_mask;

  // Per-line state and storage
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [127:0]     line_q [LINES];

  logic [IDX-1:0]   index;
  logic [TAG_W-1:0] tag;
  logic [1:0]       word;
  logic             hit;
  logic             lookup_hit;
  logic             accept;
  logic             refill_fire;
  logic [127:0]     cur_line;
  logic [31:0]      cur_word;
  logic [31:0]      merged_word;
  logic [127:0]     hit_line;
  logic             addr_lsb_unused;

  assign addr_lsb_unused = ^cpu_req_addr[1:0];

  assign index    = lat_addr[IDX+1:2];
  assign tag      = lat_addr[29:IDX+2];
  assign word     = lat_addr[1:0];
  assign cur_line = line_q[index];

  // Replace only the bytes enabled in the mask
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Word select and write-merge of the addressed line
  always_comb begin
    cur_word = cur_line[31:0];
    hit_line = cur_line;
    case (word)
      2'd0: cur_word = cur_line[31:0];
      2'd1: cur_word = cur_line[63:32];
      2'd2: cur_word = cur_line[95:64];
      default: cur_word = cur_line[127:96];
    endcase
    merged_word = merge_bytes(cur_word, lat_data, lat_mask);
    case (word)
      2'd0: hit_line[31:0]   = merged_word;
      2'd1: hit_line[63:32]  = merged_word;
      2'd2: hit_line[95:64]  = merged_word;
      default: hit_line[127:96] = merged_word;
    endcase
  end

  assign hit         = valid_q[index] && (tag_q[index] == tag);
  assign lookup_hit  = (state == LOOKUP) && hit && !reset;
  assign refill_fire = (state == REFILL_WAIT) && mem_resp_valid && !reset;

  // Handshake outputs decode from the registered state so a hit answers in LOOKUP itself
  assign cpu_req_ready  = !reset && ((state == IDLE) || lookup_hit);
  assign accept         = cpu_req_valid && cpu_req_ready;
  assign cpu_resp_valid = lookup_hit;
  assign cpu_resp_data  = (lat_mask == 4'd0) ? cur_word : merged_word;

  // Memory request fields derive only from latched request and untouched line state,
  // so they stay stable while the memory side stalls
  assign mem_req_valid = !reset && ((state == WB_REQ) || (state == REFILL_REQ));
  assign mem_req_rw    = (state == WB_REQ);
  assign mem_req_addr  = (state == WB_REQ) ? {tag_q[index], index} : lat_addr[29:2];
  assign mem_req_data  = cur_line;

  // Controller FSM plus valid/dirty bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            if (lat_mask != 4'd0) dirty_q[index] <= 1'b1;
            state <= cpu_req_valid ? LOOKUP : IDLE;
          end else if (valid_q[index] && dirty_q[index]) begin
            state <= WB_REQ;
          end else begin
            state <= REFILL_REQ;
          end
        end
        WB_REQ: begin
          if (mem_req_ready) state <= REFILL_REQ;
        end
        REFILL_REQ: begin
          if (mem_req_ready) state <= REFILL_WAIT;
        end
        REFILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
            state          <= LOOKUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the request on every accepted handshake
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr <= cpu_req_addr[31:2];
      lat_data <= cpu_req_data;
      lat_mask <= cpu_req_write;
    end
  end

  // Tag and data arrays: refill writes the whole line, write hits merge one word
  always_ff @(posedge clk) begin
    if (refill_fire) begin
      line_q[index] <= mem_resp_data;
      tag_q[index]  <= tag;
    end else if (lookup_hit && (lat_mask != 4'd0)) begin
      line_q[index] <= hit_line;
    end
  end

endmodule
